// File: rtl/lc3_pkg.sv
// Shared definitions for the 1-to-2 demultiplexer: slot state encoding
// and the default data width.
package lc3_pkg;

    localparam int DEMUX_WIDTH = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a demux output channel, with
// fill/drain state tracking and a can-accept indication for the source.
module demux_slot
    import lc3_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_free
);

    slot_state_t      r_state;
    slot_state_t      w_next;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= SLOT_EMPTY;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SLOT_EMPTY: if (i_wr)           w_next = SLOT_FULL;
            SLOT_FULL:  if (i_rdy && !i_wr) w_next = SLOT_EMPTY;
        endcase
    end

    // A full slot can take a new word in the same cycle it is drained.
    always_comb begin
        o_valid = (r_state == SLOT_FULL);
        o_free  = (r_state == SLOT_EMPTY) || i_rdy;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)     r_data <= '0;
        else if (i_wr) r_data <= i_din;
    end

    assign o_dout = r_data;

endmodule

// File: rtl/demux16_1to2.sv
// 1-to-2 valid/ready demultiplexer with one-entry output slots.
// Optional DEMUX16_COUNT_EN adds per-channel accepted-word counters CNT0/CNT1.
module demux16_1to2
    import lc3_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SEL,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] D_OUT0,
    output logic [WIDTH-1:0] D_OUT1,
    output logic             OUT0_VALID,
    output logic             OUT1_VALID,
    input  logic             OUT0_READY,
    input  logic             OUT1_READY
`ifdef DEMUX16_COUNT_EN
   ,output logic [15:0]      CNT0,
    output logic [15:0]      CNT1
`endif
);

    logic w_free0;
    logic w_free1;
    logic w_wr0;
    logic w_wr1;

    // Readiness looks only at the addressed slot, so a stall never crosses over.
    always_comb begin
        IN_READY = !RST && (SEL ? w_free1 : w_free0);
        w_wr0    = IN_VALID && IN_READY && !SEL;
        w_wr1    = IN_VALID && IN_READY &&  SEL;
    end

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_wr    (w_wr0),
        .i_din   (D_IN),
        .i_rdy   (OUT0_READY),
        .o_dout  (D_OUT0),
        .o_valid (OUT0_VALID),
        .o_free  (w_free0)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_wr    (w_wr1),
        .i_din   (D_IN),
        .i_rdy   (OUT1_READY),
        .o_dout  (D_OUT1),
        .o_valid (OUT1_VALID),
        .o_free  (w_free1)
    );

`ifdef DEMUX16_COUNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            r_cnt0 <= r_cnt0 + {15'd0, w_wr0};
            r_cnt1 <= r_cnt1 + {15'd0, w_wr1};
        end
    end

    assign CNT0 = r_cnt0;
    assign CNT1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux16_1to2.sv
// Scoreboard bench for demux16_1to2: per-channel FIFO model of accepted
// words, checked by an independent output monitor.
module tb_demux16_1to2;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        SEL = 1'b0;
    logic [15:0] D_IN = 16'h0;
    logic        IN_VALID = 1'b1;
    logic        IN_READY;
    logic [15:0] D_OUT0;
    logic [15:0] D_OUT1;
    logic        OUT0_VALID;
    logic        OUT1_VALID;
    logic        OUT0_READY = 1'b1;
    logic        OUT1_READY = 1'b1;
`ifdef DEMUX16_COUNT_EN
    logic [15:0] CNT0;
    logic [15:0] CNT1;
    logic [15:0] m_cnt0 = 16'h0;
    logic [15:0] m_cnt1 = 16'h0;
`endif

    always #5 clk = ~clk;

    demux16_1to2 #(.WIDTH(16)) dut (
        .CLK        (clk),
        .RST        (RST),
        .SEL        (SEL),
        .D_IN       (D_IN),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .D_OUT0     (D_OUT0),
        .D_OUT1     (D_OUT1),
        .OUT0_VALID (OUT0_VALID),
        .OUT1_VALID (OUT1_VALID),
        .OUT0_READY (OUT0_READY),
        .OUT1_READY (OUT1_READY)
`ifdef DEMUX16_COUNT_EN
       ,.CNT0       (CNT0),
        .CNT1       (CNT1)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive after the edge, judge acceptance before the next edge.
    task automatic cyc(input logic rst, input logic iv, input logic s,
                       input logic [15:0] d, input logic r0, input logic r1);
        logic occ0, occ1, exp_rdy;
        @(posedge clk);
        #1;
`ifdef DEMUX16_COUNT_EN
        chk("cnt0", {16'h0, CNT0}, {16'h0, m_cnt0});
        chk("cnt1", {16'h0, CNT1}, {16'h0, m_cnt1});
`endif
        RST = rst; IN_VALID = iv; SEL = s; D_IN = d;
        OUT0_READY = r0; OUT1_READY = r1;
        occ0 = (q0.size() != 0);
        occ1 = (q1.size() != 0);
        @(negedge clk);
        exp_rdy = !rst && (s ? (!occ1 || r1) : (!occ0 || r0));
        chk("in_ready", {31'h0, IN_READY}, {31'h0, exp_rdy});
        if (rst) begin
            q0.delete();
            q1.delete();
`ifdef DEMUX16_COUNT_EN
            m_cnt0 = 16'h0;
            m_cnt1 = 16'h0;
`endif
        end else if (iv && exp_rdy) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
`ifdef DEMUX16_COUNT_EN
            if (s) m_cnt1 = m_cnt1 + 16'd1;
            else   m_cnt0 = m_cnt0 + 16'd1;
`endif
        end
    endtask

    // Output monitor: valid follows model occupancy, data follows queue order.
    logic [15:0] last0 = 16'h0;
    logic [15:0] last1 = 16'h0;

    initial begin
        logic v0, v1;
        forever begin
            @(posedge clk);
            #1;
            v0 = (q0.size() != 0);
            v1 = (q1.size() != 0);
            @(negedge clk);
            chk("out0_valid", {31'h0, OUT0_VALID}, {31'h0, v0});
            chk("out1_valid", {31'h0, OUT1_VALID}, {31'h0, v1});
            if (v0) chk("d_out0", {16'h0, D_OUT0}, {16'h0, q0[0]});
            else    chk("d_out0_idle", {16'h0, D_OUT0}, {16'h0, last0});
            if (v1) chk("d_out1", {16'h0, D_OUT1}, {16'h0, q1[0]});
            else    chk("d_out1_idle", {16'h0, D_OUT1}, {16'h0, last1});
            if (RST) begin
                last0 = 16'h0;
                last1 = 16'h0;
            end else begin
                if (v0 && OUT0_READY) last0 = q0.pop_front();
                if (v1 && OUT1_READY) last1 = q1.pop_front();
            end
        end
    end

    initial begin
        // Reset held two cycles with a word offered.
        cyc(1, 1, 0, 16'hDEAD, 1, 1);
        cyc(1, 1, 1, 16'hBEEF, 1, 1);
        // Routing to both channels.
        cyc(0, 1, 0, 16'h1234, 1, 1);
        cyc(0, 1, 1, 16'h1111, 1, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1);
        // Backpressure on channel 0.
        cyc(0, 1, 0, 16'hAAAA, 0, 1);
        cyc(0, 1, 0, 16'hBBBB, 0, 1);
        cyc(0, 1, 0, 16'hBBBB, 0, 1);
        cyc(0, 1, 0, 16'hBBBB, 1, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1);
        // Stalled channel 0 must not block channel 1.
        cyc(0, 1, 0, 16'h7777, 0, 1);
        cyc(0, 1, 1, 16'h5555, 0, 1);
        cyc(0, 0, 0, 16'h0000, 0, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1);
        // Simultaneous drain and fill on channel 1.
        cyc(0, 1, 1, 16'h0001, 1, 0);
        cyc(0, 1, 1, 16'h0002, 1, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1);
        cyc(0, 0, 0, 16'h0000, 1, 1);
        // Randomized traffic with a mid-stream reset while words are held.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                cyc(0, 1, 0, 16'hC0DE, 0, 0);
                cyc(0, 1, 1, 16'hCAFE, 0, 0);
                cyc(1, 1, 0, 16'hF00D, 1, 1);
                cyc(1, 1, 1, 16'hF00D, 1, 1);
            end
            cyc(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                16'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0));
        end
`ifdef DEMUX16_COUNT_EN
        cyc(1, 0, 0, 16'h0, 1, 1);
        for (int i = 0; i < 65535; i++) cyc(0, 1, 0, 16'(i), 1, 1);
        cyc(0, 0, 0, 16'h0, 1, 1);
        chk("cnt0_preload", {16'h0, CNT0}, 32'h0000FFFF);
        cyc(0, 1, 0, 16'h4242, 1, 1);
        cyc(0, 1, 1, 16'h4343, 1, 1);
        cyc(0, 0, 0, 16'h0, 1, 1);
        chk("cnt0_wrap", {16'h0, CNT0}, 32'h0);
        cyc(1, 1, 1, 16'h0, 1, 1);
        cyc(0, 0, 0, 16'h0, 1, 1);
        chk("cnt_reset", {CNT0, CNT1}, 32'h0);
`endif
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'h0, 1, 1);
        @(posedge clk);
        #1;
        chk("drained", q0.size() + q1.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
